// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder
// Operand feeder for serial_pe. Accepts dot-product instructions (N lines each),
// reads 512-bit neuron/weight lines from a one-cycle-latency line memory and
// streams them out one 16-bit element per cycle, most significant element first.
// A follow-on instruction accepted during the prefetch slot of the last line is
// streamed with no bubble.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   inst_vld, inst, inst_rdy    instruction handshake (inst = line count N)
//   mem_rd_en, mem_rd_addr      line read strobe and address
//   mem_neuron_line/weight_line read data, valid the cycle after mem_rd_en
//   pe_neuron, pe_weight        element operands to serial_pe
//   pe_ctl                      [0] first element, [1] last element of instruction
//   pe_vld                      element valid
//   busy                        block is not idle
module pe_operand_feeder #(
  parameter int DATA_W = 16,
  parameter int ELEMS  = 32,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inst_vld,
  input  logic [7:0]               inst,
  output logic                     inst_rdy,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [DATA_W*ELEMS-1:0]  mem_neuron_line,
  input  logic [DATA_W*ELEMS-1:0]  mem_weight_line,
  output logic [DATA_W-1:0]        pe_neuron,
  output logic [DATA_W-1:0]        pe_weight,
  output logic [1:0]               pe_ctl,
  output logic                     pe_vld,
  output logic                     busy
);

  localparam int LINE_W = DATA_W * ELEMS;
  localparam int IDX_W  = $clog2(ELEMS);
  // Slot where the next line is prefetched so its data lands exactly at the last slot.
  localparam logic [IDX_W-1:0] PRE_IDX  = IDX_W'(ELEMS - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [IDX_W-1:0]    idx_r;
  logic [7:0]          line_cnt_r;
  logic [ADDR_W-1:0]   line_addr_r;
  logic [LINE_W-1:0]   cur_neuron_r;
  logic [LINE_W-1:0]   cur_weight_r;
  logic                first_r;     // current line is the first line of its instruction
  logic                rd_pend_r;   // a read was issued in the prefetch slot
  logic                new_inst_r;  // that read belongs to a newly accepted instruction
  logic [7:0]          next_n_r;    // line count of the follow-on instruction
  logic                rd_en_s;
  logic                rdy_s;
  logic                new_ok_s;

  assign new_ok_s    = inst_vld && (inst != 8'd0);
  assign inst_rdy    = rdy_s;
  assign mem_rd_en   = rd_en_s;
  assign mem_rd_addr = line_addr_r;
  assign busy        = (state_r != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, handshake and read-strobe decode
  always_comb begin
    state_nx_s = state_r;
    rdy_s      = 1'b0;
    rd_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        rdy_s = 1'b1;
        if (new_ok_s) begin
          rd_en_s    = 1'b1;
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        state_nx_s = RUN;
      end
      RUN: begin
        if (idx_r == PRE_IDX) begin
          state_nx_s = RUN;
          if (line_cnt_r > 8'd1) begin
            rd_en_s = 1'b1;
          end else begin
            // Last line of the instruction: open the window for a follow-on.
            rdy_s   = 1'b1;
            rd_en_s = new_ok_s;
          end
        end else if (idx_r == LAST_IDX) begin
          if (rd_pend_r) begin
            state_nx_s = RUN;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Free-running line address, advanced once per issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr_r <= '0;
    end else if (rd_en_s) begin
      line_addr_r <= line_addr_r + ADDR_W'(1);
    end else begin
      line_addr_r <= line_addr_r;
    end
  end

  // Line buffers, element index, line counter and follow-on bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= '0;
      line_cnt_r   <= 8'd0;
      cur_neuron_r <= '0;
      cur_weight_r <= '0;
      first_r      <= 1'b0;
      rd_pend_r    <= 1'b0;
      new_inst_r   <= 1'b0;
      next_n_r     <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (new_ok_s) begin
            line_cnt_r <= inst;
            first_r    <= 1'b1;
          end
        end
        LOAD: begin
          cur_neuron_r <= mem_neuron_line;
          cur_weight_r <= mem_weight_line;
          idx_r        <= '0;
        end
        RUN: begin
          idx_r <= idx_r + IDX_W'(1);
          if (idx_r == PRE_IDX) begin
            rd_pend_r  <= rd_en_s;
            new_inst_r <= (line_cnt_r == 8'd1) && new_ok_s;
            next_n_r   <= inst;
          end else if (idx_r == LAST_IDX) begin
            rd_pend_r  <= 1'b0;
            new_inst_r <= 1'b0;
            if (rd_pend_r) begin
              cur_neuron_r <= mem_neuron_line;
              cur_weight_r <= mem_weight_line;
              first_r      <= new_inst_r;
              line_cnt_r   <= new_inst_r ? next_n_r : (line_cnt_r - 8'd1);
            end else begin
              first_r    <= 1'b0;
              line_cnt_r <= 8'd0;
            end
          end
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Element select and stream markers; outputs are quiet outside RUN
  always_comb begin
    pe_vld    = 1'b0;
    pe_ctl    = 2'b00;
    pe_neuron = '0;
    pe_weight = '0;
    if (state_r == RUN) begin
      pe_vld    = 1'b1;
      pe_neuron = cur_neuron_r[DATA_W*(ELEMS-1-int'(idx_r)) +: DATA_W];
      pe_weight = cur_weight_r[DATA_W*(ELEMS-1-int'(idx_r)) +: DATA_W];
      pe_ctl[0] = first_r && (idx_r == '0);
      pe_ctl[1] = (line_cnt_r == 8'd1) && (idx_r == LAST_IDX);
    end else begin
      pe_vld = 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed testbench for pe_operand_feeder. A line-memory model serves
// deterministic content per address; a monitor checks every streamed element,
// marker and read address against queues the bench fills for each instruction.
module tb_pe_operand_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inst_vld;
  logic [7:0]   inst;
  logic         inst_rdy;
  logic         mem_rd_en;
  logic [10:0]  mem_rd_addr;
  logic [511:0] mem_neuron_line;
  logic [511:0] mem_weight_line;
  logic [15:0]  pe_neuron;
  logic [15:0]  pe_weight;
  logic [1:0]   pe_ctl;
  logic         pe_vld;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [33:0] exp_q[$];
  int          exp_rd_q[$];
  int          exp_addr;

  int acc_q[$];
  int rd_cyc_q[$];
  int rd_addr_q[$];
  int ctl0_q[$];
  int ctl1_q[$];
  int vld_cnt;
  int first_vld;
  int last_vld;

  pe_operand_feeder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_vld        (inst_vld),
    .inst            (inst),
    .inst_rdy        (inst_rdy),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_neuron_line (mem_neuron_line),
    .mem_weight_line (mem_weight_line),
    .pe_neuron       (pe_neuron),
    .pe_weight       (pe_weight),
    .pe_ctl          (pe_ctl),
    .pe_vld          (pe_vld),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] nel(input int a, input int e);
    return {5'(e), 11'(a)};
  endfunction

  function automatic logic [15:0] wel(input int a, input int e);
    return 16'hA5A5 ^ {11'(a), 5'(e)};
  endfunction

  // Line memory: element 0 occupies the top 16 bits of the line.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int e = 0; e < 32; e++) begin
        mem_neuron_line[16*(31-e) +: 16] <= nel(int'(mem_rd_addr), e);
        mem_weight_line[16*(31-e) +: 16] <= wel(int'(mem_rd_addr), e);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_list(input string tag, input int act[$], input int expv[$]);
    check_eq({tag, "_count"}, act.size(), expv.size());
    for (int i = 0; i < expv.size(); i++) begin
      check_eq(tag, (i < act.size()) ? act[i] : -1, expv[i]);
    end
  endtask

  task automatic push_inst(input int n);
    for (int l = 0; l < n; l++) begin
      int a;
      a = (exp_addr + l) % 2048;
      exp_rd_q.push_back(a);
      for (int e = 0; e < 32; e++) begin
        logic [1:0] c;
        c[0] = (l == 0) && (e == 0);
        c[1] = (l == n - 1) && (e == 31);
        exp_q.push_back({c, nel(a, e), wel(a, e)});
      end
    end
    exp_addr = (exp_addr + n) % 2048;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    rd_cyc_q.delete();
    rd_addr_q.delete();
    ctl0_q.delete();
    ctl1_q.delete();
    vld_cnt   = 0;
    first_vld = -1;
    last_vld  = -1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (inst_vld && inst_rdy) acc_q.push_back(cyc);
        if (mem_rd_en) begin
          rd_cyc_q.push_back(cyc);
          rd_addr_q.push_back(int'(mem_rd_addr));
          if (exp_rd_q.size() == 0) check_eq("rd_extra", 1, 0);
          else check_eq("rd_addr", mem_rd_addr, exp_rd_q.pop_front());
        end
        if (pe_vld) begin
          vld_cnt++;
          if (first_vld < 0) first_vld = cyc;
          last_vld = cyc;
          if (pe_ctl[0]) ctl0_q.push_back(vld_cnt);
          if (pe_ctl[1]) ctl1_q.push_back(vld_cnt);
          if (exp_q.size() == 0) check_eq("vld_extra", 1, 0);
          else check_eq("stream", {pe_ctl, pe_neuron, pe_weight}, exp_q.pop_front());
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted.
  task automatic send(input logic [7:0] n);
    int k;
    k = 0;
    inst     = n;
    inst_vld = 1'b1;
    @(negedge clk);
    while (!inst_rdy && k < 10000) begin
      @(negedge clk);
      k++;
    end
    if (!inst_rdy) check_eq("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    inst_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_reached", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag);
    check_eq({tag, "_stream_left"}, exp_q.size(), 0);
    check_eq({tag, "_reads_left"}, exp_rd_q.size(), 0);
  endtask

  initial begin
    int t;
    int l_cyc;
    int k;
    int rem;
    int e_list[$];
    int a_list[$];

    rst_n    = 1'b0;
    inst_vld = 1'b0;
    inst     = 8'd0;
    exp_addr = 0;
    clear_logs();
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_inst_rdy", inst_rdy, 1);
    check_eq("rst_rd_en", mem_rd_en, 0);
    check_eq("rst_rd_addr", mem_rd_addr, 0);
    check_eq("rst_pe_vld", pe_vld, 0);
    check_eq("rst_pe_ctl", pe_ctl, 0);
    check_eq("rst_pe_neuron", pe_neuron, 0);
    check_eq("rst_pe_weight", pe_weight, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single one-line instruction
    clear_logs();
    push_inst(1);
    send(8'd1);
    wait_idle(200);
    t = (acc_q.size() > 0) ? acc_q[0] : -1000;
    e_list = '{t};
    check_list("t1_rd_cyc", rd_cyc_q, e_list);
    check_eq("t1_vld_cnt", vld_cnt, 32);
    check_eq("t1_first_vld", first_vld, t + 2);
    check_eq("t1_last_vld", last_vld, t + 33);
    e_list = '{1};
    check_list("t1_ctl0", ctl0_q, e_list);
    e_list = '{32};
    check_list("t1_ctl1", ctl1_q, e_list);
    end_checks("t1");

    // Three-line instruction
    clear_logs();
    push_inst(3);
    send(8'd3);
    wait_idle(400);
    t = (acc_q.size() > 0) ? acc_q[0] : -1000;
    e_list = '{t, t + 32, t + 64};
    check_list("t2_rd_cyc", rd_cyc_q, e_list);
    a_list = '{1, 2, 3};
    check_list("t2_rd_addr", rd_addr_q, a_list);
    check_eq("t2_vld_cnt", vld_cnt, 96);
    check_eq("t2_first_vld", first_vld, t + 2);
    check_eq("t2_last_vld", last_vld, t + 97);
    e_list = '{96};
    check_list("t2_ctl1", ctl1_q, e_list);
    end_checks("t2");

    // Back-to-back instructions with inst_vld held
    clear_logs();
    push_inst(1);
    push_inst(2);
    push_inst(3);
    push_inst(4);
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    wait_idle(1000);
    check_eq("t3_vld_cnt", vld_cnt, 320);
    check_eq("t3_gapless", last_vld - first_vld + 1, 320);
    a_list = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    check_list("t3_rd_addr", rd_addr_q, a_list);
    e_list = '{32, 96, 192, 320};
    check_list("t3_ctl1", ctl1_q, e_list);
    e_list = '{1, 33, 97, 193};
    check_list("t3_ctl0", ctl0_q, e_list);
    end_checks("t3");

    // Zero-length instruction in IDLE
    clear_logs();
    send(8'd0);
    repeat (3) @(negedge clk);
    check_eq("t4_accepted", acc_q.size(), 1);
    check_eq("t4_reads", rd_cyc_q.size(), 0);
    check_eq("t4_vld", vld_cnt, 0);
    check_eq("t4_inst_rdy", inst_rdy, 1);
    check_eq("t4_busy", busy, 0);
    @(posedge clk);
    #1;

    // Instruction arriving after the follow-on window
    clear_logs();
    push_inst(1);
    send(8'd1);
    k = 0;
    @(negedge clk);
    while (!(pe_vld && pe_ctl[1]) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("t5_last_seen", pe_vld && pe_ctl[1], 1);
    l_cyc = cyc;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    clear_logs();
    push_inst(1);
    send(8'd1);
    wait_idle(200);
    check_eq("t5_accept_cyc", (acc_q.size() > 0) ? acc_q[0] : -1, l_cyc + 3);
    check_eq("t5_restart_gap", first_vld - l_cyc, 5);
    a_list = '{15};
    check_list("t5_rd_addr", rd_addr_q, a_list);
    end_checks("t5");

    // Address wrap: consume lines up to 2045, then a 4-line instruction crosses 2047 -> 0
    clear_logs();
    rem = 2046 - exp_addr;
    while (rem > 0) begin
      k = (rem > 255) ? 255 : rem;
      push_inst(k);
      send(8'(k));
      rem -= k;
    end
    push_inst(4);
    send(8'd4);
    wait_idle(70000);
    a_list.delete();
    for (int i = 4; i > 0; i--) begin
      a_list.push_back((rd_addr_q.size() >= i) ? rd_addr_q[rd_addr_q.size() - i] : -1);
    end
    e_list = '{2046, 2047, 0, 1};
    check_list("t6_wrap_addr", a_list, e_list);
    check_eq("t6_gapless", last_vld - first_vld + 1, vld_cnt);
    end_checks("t6");

    // Reset in the middle of line 1, element 10
    clear_logs();
    push_inst(3);
    send(8'd3);
    t = (acc_q.size() > 0) ? acc_q[0] : -1000;
    k = 0;
    while (cyc != t + 44 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("t7_pre_vld", pe_vld, 1);
    check_eq("t7_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_vld", pe_vld, 0);
    check_eq("t7_rst_busy", busy, 0);
    check_eq("t7_rst_ctl", pe_ctl, 0);
    check_eq("t7_rst_addr", mem_rd_addr, 0);
    check_eq("t7_rst_rd_en", mem_rd_en, 0);
    exp_q.delete();
    exp_rd_q.delete();
    exp_addr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    push_inst(2);
    send(8'd2);
    wait_idle(300);
    a_list = '{0, 1};
    check_list("t7_rd_addr", rd_addr_q, a_list);
    check_eq("t7_vld_cnt", vld_cnt, 64);
    e_list = '{1};
    check_list("t7_ctl0", ctl0_q, e_list);
    e_list = '{64};
    check_list("t7_ctl1", ctl1_q, e_list);
    end_checks("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
